// File: rtl/cog_hub_pkg.sv
// Shared encodings for the cog hub port: transfer sizes, sys codes, FSM states
// and small address/counter helpers.
package cog_hub_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_LONG = 2'b10,
    SZ_SYS  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    SYS_CLKSET  = 3'd0,
    SYS_COGID   = 3'd1,
    SYS_COGINIT = 3'd2,
    SYS_COGSTOP = 3'd3,
    SYS_LOCKNEW = 3'd4,
    SYS_LOCKRET = 3'd5,
    SYS_LOCKSET = 3'd6,
    SYS_LOCKCLR = 3'd7
  } sys_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLOT,
    ST_ACK
  } state_e;

  // Long and word accesses are naturally aligned; byte and sys codes pass through.
  function automatic logic [15:0] align_addr(input logic [1:0] s, input logic [15:0] a);
    logic [15:0] r;
    r = a;
    case (s)
      SZ_LONG: r[1:0] = 2'b00;
      SZ_WORD: r[0]   = 1'b0;
      default: r      = a;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cog_hub_waitcnt.sv
// Saturating 16-bit wait-cycle counter; present only when HUB_WAIT_STATS_EN is defined.
`ifdef HUB_WAIT_STATS_EN
module cog_hub_waitcnt
  import cog_hub_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt_next
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc)
      cnt_d = sat_inc16(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_next = cnt_d;

endmodule
`endif

// File: rtl/cog_hub_port.sv
// Cog-side hub request port: latches one request, waits for the hub slot and ack.
// Optional wait-cycle statistics on last_wait when HUB_WAIT_STATS_EN is defined.
module cog_hub_port
  import cog_hub_pkg::*;
(
  input  logic        clk_cog,
  input  logic        res,
  input  logic        ena_bus,
  input  logic        bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_q,
  input  logic        bus_c,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_w,
  input  logic [1:0]  req_s,
  input  logic [15:0] req_a,
  input  logic [31:0] req_d,
  output logic        bus_r,
  output logic        bus_e,
  output logic        bus_w,
  output logic [1:0]  bus_s,
  output logic [15:0] bus_a,
  output logic [31:0] bus_d,
  output logic        rsp_valid,
  output logic [31:0] rsp_q,
  output logic        rsp_c,
  output logic [15:0] last_wait
);

  state_e      state_q, state_d;
  logic        bus_r_q, bus_r_d;
  logic        bus_w_q, bus_w_d;
  logic [1:0]  bus_s_q, bus_s_d;
  logic [15:0] bus_a_q, bus_a_d;
  logic [31:0] bus_d_q, bus_d_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_c_q, rsp_c_d;
  logic        accept, done;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign done   = (state_q == ST_ACK) && ena_bus && bus_ack;

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid)          state_d = ST_SLOT;
      ST_SLOT: if (ena_bus && bus_sel) state_d = ST_ACK;
      ST_ACK:  if (ena_bus && bus_ack) state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    bus_e     = (state_q == ST_SLOT);
  end

  always_comb begin
    bus_r_d     = bus_r_q;
    bus_w_d     = bus_w_q;
    bus_s_d     = bus_s_q;
    bus_a_d     = bus_a_q;
    bus_d_d     = bus_d_q;
    rsp_valid_d = done;
    rsp_data_d  = rsp_data_q;
    rsp_c_d     = rsp_c_q;
    if (accept) begin
      bus_r_d = !req_w && (req_s != SZ_SYS);
      bus_w_d = req_w;
      bus_s_d = req_s;
      bus_a_d = align_addr(req_s, req_a);
      bus_d_d = req_d;
    end
    if (done) begin
      rsp_data_d = bus_q;
      rsp_c_d    = bus_c;
    end
  end

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      bus_r_q     <= 1'b0;
      bus_w_q     <= 1'b0;
      bus_s_q     <= '0;
      bus_a_q     <= '0;
      bus_d_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_c_q     <= 1'b0;
    end else begin
      bus_r_q     <= bus_r_d;
      bus_w_q     <= bus_w_d;
      bus_s_q     <= bus_s_d;
      bus_a_q     <= bus_a_d;
      bus_d_q     <= bus_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_c_q     <= rsp_c_d;
    end
  end

  assign bus_r     = bus_r_q;
  assign bus_w     = bus_w_q;
  assign bus_s     = bus_s_q;
  assign bus_a     = bus_a_q;
  assign bus_d     = bus_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = rsp_data_q;
  assign rsp_c     = rsp_c_q;

`ifdef HUB_WAIT_STATS_EN
  logic [15:0] wait_next;
  logic [15:0] last_wait_q, last_wait_d;

  // The copy on completion includes the completing cycle itself.
  cog_hub_waitcnt u_waitcnt (
    .clk      (clk_cog),
    .rst      (res),
    .clr      (accept),
    .inc      (state_q != ST_IDLE),
    .cnt_next (wait_next)
  );

  always_comb begin
    last_wait_d = last_wait_q;
    if (done) last_wait_d = wait_next;
  end

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) last_wait_q <= '0;
    else     last_wait_q <= last_wait_d;
  end

  assign last_wait = last_wait_q;
`else
  assign last_wait = '0;
`endif

endmodule
